// File: rtl/cmp_share_arb_if.sv
// Bundle of requester, shared-comparator and response signals for cmp_share_arb.
// The arbiter connects through the slave modport; the requester side uses master.
interface cmp_share_arb_if #(
  parameter int SIG_WIDTH = 7,
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*SIG_WIDTH-1:0] req_x;
  logic [NUM_REQ*SIG_WIDTH-1:0] req_y;
  logic [SIG_WIDTH-1:0]         cmp_x;
  logic [SIG_WIDTH-1:0]         cmp_y;
  logic                         cmp_x_grtr_y;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic                         rsp_x_grtr_y;
  logic [ID_W-1:0]              rsp_id;
  logic                         busy;

  modport slave (
    input  req_valid, req_x, req_y, cmp_x_grtr_y,
    output req_ready, cmp_x, cmp_y, rsp_valid, rsp_x_grtr_y, rsp_id, busy
  );

  modport master (
    output req_valid, req_x, req_y, cmp_x_grtr_y,
    input  req_ready, cmp_x, cmp_y, rsp_valid, rsp_x_grtr_y, rsp_id, busy
  );
endinterface

// File: rtl/cmp_share_arb.sv
// Round-robin sequencer time-sharing one external unsigned x>y comparator among
// NUM_REQ requesters: grant, compare, respond -- one operation every 3 clocks.
module cmp_share_arb #(
  parameter int SIG_WIDTH = 7,
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  cmp_share_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [ID_W-1:0]      last_grant_r;
  logic [ID_W-1:0]      rsp_id_r;
  logic [ID_W-1:0]      grant_s;
  logic [ID_W-1:0]      idx_s;
  logic                 found_s;
  logic                 hit_s;
  logic                 take_s;
  int                   sum_s;
  logic [NUM_REQ-1:0]   ready_s;
  logic [NUM_REQ-1:0]   rsp_valid_r;
  logic [SIG_WIDTH-1:0] cmp_x_r;
  logic [SIG_WIDTH-1:0] cmp_y_r;
  logic [SIG_WIDTH-1:0] sel_x_s;
  logic [SIG_WIDTH-1:0] sel_y_s;
  logic                 rsp_x_r;
  logic                 busy_r;

  function automatic logic [NUM_REQ-1:0] one_hot(input logic [ID_W-1:0] idx);
    one_hot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin search starting one past the last grant, wrapping at NUM_REQ
  always_comb begin
    found_s = 1'b0;
    grant_s = '0;
    sum_s   = 0;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum_s   = int'(last_grant_r) + k;
      idx_s   = ID_W'((sum_s >= NUM_REQ) ? (sum_s - NUM_REQ) : sum_s);
      hit_s   = ~found_s & bus.req_valid[idx_s];
      grant_s = hit_s ? idx_s : grant_s;
      found_s = found_s | hit_s;
    end
  end

  // Operand slice of the granted requester
  always_comb begin
    sel_x_s = '0;
    sel_y_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_x_s = (grant_s == ID_W'(i)) ? bus.req_x[i*SIG_WIDTH +: SIG_WIDTH] : sel_x_s;
      sel_y_s = (grant_s == ID_W'(i)) ? bus.req_y[i*SIG_WIDTH +: SIG_WIDTH] : sel_y_s;
    end
  end

  // Next-state logic and the combinational ready toward the granted requester
  always_comb begin
    state_s = state_r;
    take_s  = 1'b0;
    ready_s = '0;
    case (state_r)
      IDLE: begin
        // ready is held low while reset is asserted, even though the search is live
        if (found_s && rst_n) begin
          take_s  = 1'b1;
          ready_s = one_hot(grant_s);
          state_s = COMPARE;
        end else begin
          state_s = IDLE;
        end
      end
      COMPARE: state_s = RESPOND;
      RESPOND: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register, operand capture, result capture and response pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= ID_W'(NUM_REQ - 1);
      rsp_id_r     <= '0;
      cmp_x_r      <= '0;
      cmp_y_r      <= '0;
      rsp_x_r      <= 1'b0;
      rsp_valid_r  <= '0;
      busy_r       <= 1'b0;
    end else begin
      state_r <= state_s;
      if (take_s) begin
        cmp_x_r      <= sel_x_s;
        cmp_y_r      <= sel_y_s;
        rsp_id_r     <= grant_s;
        last_grant_r <= grant_s;
        busy_r       <= 1'b1;
      end
      if (state_r == COMPARE) begin
        rsp_x_r     <= bus.cmp_x_grtr_y;
        rsp_valid_r <= one_hot(rsp_id_r);
      end else if (state_r == RESPOND) begin
        rsp_valid_r <= '0;
        busy_r      <= 1'b0;
      end
    end
  end

  assign bus.req_ready    = ready_s;
  assign bus.cmp_x        = cmp_x_r;
  assign bus.cmp_y        = cmp_y_r;
  assign bus.rsp_valid    = rsp_valid_r;
  assign bus.rsp_x_grtr_y = rsp_x_r;
  assign bus.rsp_id       = rsp_id_r;
  assign bus.busy         = busy_r;

endmodule
